// File: rtl/proc_pkg.sv
// Shared opcode, ALU-select and FSM state definitions for the 4-bit processor sequencer.
// Pure declarations: no latency and no backpressure.
package proc_pkg;

  localparam int OPC_W = 4;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0101;
  localparam logic [3:0] OP_STORE = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } seq_state_t;

  // Undefined opcodes behave exactly like NOP: advance and fetch again.
  function automatic logic op_is_nop(input logic [3:0] opc);
    return (opc == OP_NOP) ||
           !(opc inside {OP_ADD, OP_SUB, OP_LOAD, OP_STORE, OP_JMP, OP_HALT});
  endfunction

endpackage

// File: rtl/seq_pc.sv
// Program counter register with clear > load > increment priority, wrapping modulo 2^PC_W.
// Latency: updates on the clock edge after the control is sampled; no backpressure.
module seq_pc #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            ld,
  input  logic            inc,
  input  logic [PC_W-1:0] ld_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (ld) begin
      pc <= ld_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, fetches, decodes, and drives ALU/regfile/dmem strobes.
// Latency: NOP/JMP 2, ADD/SUB/STORE 3, LOAD 4 cycles at zero wait; strobes hold until ack.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W  = 4,
  parameter int OPR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [OPC_W+OPR_W-1:0] imem_rdata,
  output logic                   dmem_re,
  output logic                   mem_we,
  output logic [OPR_W-1:0]       dmem_addr,
  input  logic                   dmem_ack,
  output logic [2:0]             alu_op,
  output logic                   reg_we,
  output logic [PC_W-1:0]        pc,
  output logic                   busy,
  output logic                   halted
);

  localparam int IR_W = OPC_W + OPR_W;

  seq_state_t       state;
  logic [IR_W-1:0]  ir;
  logic [OPC_W-1:0] opcode;
  logic [OPR_W-1:0] operand;
  logic             pc_clr;
  logic             pc_ld;
  logic             pc_inc;

  assign opcode  = ir[IR_W-1 -: OPC_W];
  assign operand = ir[OPR_W-1:0];

  assign imem_addr = pc;
  assign dmem_addr = operand;

  assign pc_clr = ((state == S_IDLE) || (state == S_HALT)) && start;
  assign pc_ld  = (state == S_DECODE) && (opcode == OP_JMP);
  assign pc_inc = ((state == S_DECODE) && op_is_nop(opcode)) ||
                  (state == S_EXECUTE) || (state == S_WRITEBACK) ||
                  ((state == S_MEM) && dmem_ack && (opcode == OP_STORE));

  seq_pc #(.PC_W(PC_W)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (pc_clr),
    .ld     (pc_ld),
    .inc    (pc_inc),
    .ld_val (PC_W'(operand)),
    .pc     (pc)
  );

  // Strobes are registered against the state being entered, so each one is
  // high for exactly the cycles spent in its state and never follows an ack combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ir       <= '0;
      imem_req <= 1'b0;
      dmem_re  <= 1'b0;
      mem_we   <= 1'b0;
      alu_op   <= ALU_NONE;
      reg_we   <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      alu_op <= ALU_NONE;
      unique case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            halted   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_SUB: begin
              state  <= S_EXECUTE;
              alu_op <= (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
              reg_we <= 1'b1;
            end
            OP_LOAD: begin
              state   <= S_MEM;
              dmem_re <= 1'b1;
            end
            OP_STORE: begin
              state  <= S_MEM;
              mem_we <= 1'b1;
            end
            OP_HALT: begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            default: begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end
          endcase
        end
        S_EXECUTE, S_WRITEBACK: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_re <= 1'b0;
            mem_we  <= 1'b0;
            if (opcode == OP_LOAD) begin
              state  <= S_WRITEBACK;
              reg_we <= 1'b1;
            end else begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: directed programs push expected events; a monitor pops and compares them.
module tb_instr_sequencer;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  alu;
    logic [3:0]  val;
    logic        re;
    logic        we;
    logic [7:0]  len;
    logic [15:0] rel;
  } ev_t;

  localparam logic [2:0] EV_FETCH = 3'd1;
  localparam logic [2:0] EV_WB    = 3'd2;
  localparam logic [2:0] EV_MEM   = 3'd3;
  localparam logic [2:0] EV_HALT  = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       dmem_re;
  logic       mem_we;
  logic [3:0] dmem_addr;
  logic       dmem_ack;
  logic       dack_resp = 1'b0;
  logic       force_dack = 1'b0;
  logic [2:0] alu_op;
  logic       reg_we;
  logic [3:0] pc;
  logic       busy;
  logic       halted;

  assign dmem_ack = dack_resp | force_dack;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(4), .OPR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_re    (dmem_re),
    .mem_we     (mem_we),
    .dmem_addr  (dmem_addr),
    .dmem_ack   (dmem_ack),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted)
  );

  int   compared = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   iwait = 0;
  int   dwait = 0;
  int   icnt = 0;
  int   dcnt = 0;
  int   mlen = 0;
  logic halted_q = 1'b0;

  logic [7:0] istream[$];
  ev_t        exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responders: instruction words come from a program stream in fetch order.
  always @(negedge clk) begin
    if (imem_req) begin
      if (icnt >= iwait) begin
        imem_ack = 1'b1;
        if (istream.size() > 0) imem_rdata = istream.pop_front();
        else imem_rdata = 8'hF0;
        icnt = 0;
      end else begin
        imem_ack = 1'b0;
        icnt++;
      end
    end else begin
      imem_ack = 1'b0;
      icnt = 0;
    end
    if (dmem_re || mem_we) begin
      if (dcnt >= dwait) begin
        dack_resp = 1'b1;
        dcnt = 0;
      end else begin
        dack_resp = 1'b0;
        dcnt++;
      end
    end else begin
      dack_resp = 1'b0;
      dcnt = 0;
    end
  end

  task automatic push(input logic [2:0] kind, input logic [2:0] alu, input logic [3:0] val,
                      input logic re, input logic we, input int len, input int rel);
    ev_t e;
    e.kind = kind; e.alu = alu; e.val = val; e.re = re; e.we = we;
    e.len = 8'(len); e.rel = 16'(rel);
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input ev_t act);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d alu=%b val=%h re=%b we=%b len=%0d rel=%0d, wanted none",
               act.kind, act.alu, act.val, act.re, act.we, act.len, act.rel);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL event: got kind=%0d alu=%b val=%h re=%b we=%b len=%0d rel=%0d, wanted kind=%0d alu=%b val=%h re=%b we=%b len=%0d rel=%0d",
                 act.kind, act.alu, act.val, act.re, act.we, act.len, act.rel,
                 e.kind, e.alu, e.val, e.re, e.we, e.len, e.rel);
      end
    end
  endtask

  task automatic mk_check(input logic [2:0] kind, input logic [2:0] alu, input logic [3:0] val,
                          input logic re, input logic we, input int len);
    ev_t a;
    a.kind = kind; a.alu = alu; a.val = val; a.re = re; a.we = we;
    a.len = 8'(len); a.rel = 16'(cyc - t0);
    check_ev(a);
  endtask

  // Monitor samples 1 time unit after the falling edge, away from the active edge.
  always @(negedge clk) begin
    #1;
    compared++;
    if ((int'(reg_we) + int'(mem_we) + int'(dmem_re)) > 1 || (alu_op != 3'b000 && !reg_we)) begin
      errors++;
      $display("FAIL strobe_excl: got reg_we=%b mem_we=%b dmem_re=%b alu_op=%b, wanted at most one strobe and alu_op=000 without reg_we",
               reg_we, mem_we, dmem_re, alu_op);
    end
    if (dmem_re || mem_we) mlen++;
    else mlen = 0;
    if (imem_req && imem_ack) mk_check(EV_FETCH, 3'b000, imem_addr, 1'b0, 1'b0, 0);
    if (reg_we) mk_check(EV_WB, alu_op, pc, 1'b0, 1'b0, 0);
    if ((dmem_re || mem_we) && dmem_ack) mk_check(EV_MEM, 3'b000, dmem_addr, dmem_re, mem_we, mlen);
    if (halted && !halted_q) mk_check(EV_HALT, 3'b000, pc, 1'b0, 1'b0, 0);
    halted_q = halted;
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      compared++;
      errors++;
      $display("FAIL %s_timeout: got halted=0 after %0d cycles, wanted halted=1", name, n);
    end
    repeat (3) @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, wanted bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_dmem_re", dmem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ADD 3, SUB 1, HALT at zero wait; extra start in the HALT decode cycle must be ignored.
    istream = '{8'h13, 8'h21, 8'hF0};
    iwait = 0; dwait = 0;
    push(EV_FETCH, 3'b000, 4'h0, 1'b0, 1'b0, 0, 1);
    push(EV_WB,    3'b001, 4'h0, 1'b0, 1'b0, 0, 3);
    push(EV_FETCH, 3'b000, 4'h1, 1'b0, 1'b0, 0, 4);
    push(EV_WB,    3'b010, 4'h1, 1'b0, 1'b0, 0, 6);
    push(EV_FETCH, 3'b000, 4'h2, 1'b0, 1'b0, 0, 7);
    push(EV_HALT,  3'b000, 4'h2, 1'b0, 1'b0, 0, 9);
    pulse_start();
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halt("prog_arith");
    chk("arith_halted", halted, 1);
    chk("arith_busy", busy, 0);
    chk("arith_pc", pc, 2);

    // LOAD 9 with two dmem wait cycles, then HALT.
    istream = '{8'h59, 8'hF0};
    iwait = 0; dwait = 2;
    push(EV_FETCH, 3'b000, 4'h0, 1'b0, 1'b0, 0, 1);
    push(EV_MEM,   3'b000, 4'h9, 1'b1, 1'b0, 3, 5);
    push(EV_WB,    3'b000, 4'h0, 1'b0, 1'b0, 0, 6);
    push(EV_FETCH, 3'b000, 4'h1, 1'b0, 1'b0, 0, 7);
    push(EV_HALT,  3'b000, 4'h1, 1'b0, 1'b0, 0, 9);
    pulse_start();
    wait_halt("prog_load");

    // STORE 4 with one wait cycle on both memories; no register write expected.
    istream = '{8'h64, 8'hF0};
    iwait = 1; dwait = 1;
    push(EV_FETCH, 3'b000, 4'h0, 1'b0, 1'b0, 0, 2);
    push(EV_MEM,   3'b000, 4'h4, 1'b0, 1'b1, 2, 5);
    push(EV_FETCH, 3'b000, 4'h1, 1'b0, 1'b0, 0, 7);
    push(EV_HALT,  3'b000, 4'h1, 1'b0, 1'b0, 0, 9);
    pulse_start();
    wait_halt("prog_store");

    // JMP F, NOP wraps to 0, JMP 5, undefined 1010 acts as NOP; start while busy ignored.
    istream = '{8'h7F, 8'h00, 8'h75, 8'hA3, 8'hF0};
    iwait = 0; dwait = 0;
    push(EV_FETCH, 3'b000, 4'h0, 1'b0, 1'b0, 0, 1);
    push(EV_FETCH, 3'b000, 4'hF, 1'b0, 1'b0, 0, 3);
    push(EV_FETCH, 3'b000, 4'h0, 1'b0, 1'b0, 0, 5);
    push(EV_FETCH, 3'b000, 4'h5, 1'b0, 1'b0, 0, 7);
    push(EV_FETCH, 3'b000, 4'h6, 1'b0, 1'b0, 0, 9);
    push(EV_HALT,  3'b000, 4'h6, 1'b0, 1'b0, 0, 11);
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halt("prog_flow");

    // Reset asserted in the second MEM cycle of a STORE; a late dmem_ack must be ignored.
    istream = '{8'h64};
    iwait = 0; dwait = 50;
    push(EV_FETCH, 3'b000, 4'h0, 1'b0, 1'b0, 0, 1);
    pulse_start();
    repeat (3) @(negedge clk);
    #1;
    chk("store_we_before_rst", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    force_dack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mem_we", mem_we, 0);
    chk("post_rst_reg_we", reg_we, 0);
    chk("post_rst_pc", pc, 0);
    chk("post_rst_halted", halted, 0);
    force_dack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_drained", exp_q.size(), 0);
    chk("rst_stream_used", istream.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/decode/execute sequencer for the 4-bit processor. Fetches 8-bit instruction words from instruction memory, decodes the opcode, and drives the ALU operation select, register-file write enable and data-memory strobes one phase at a time. It owns the program counter and sits between the instruction/data memories and the ALU/register-file datapath.

## Interface
- PC_W, 4, program counter and instruction address width
- OPR_W, 4, operand field width; instruction word is 4-bit opcode + OPR_W operand
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins execution from PC=0
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  4+OPR_W  instruction word: [7:4] opcode, [3:0] operand
- dmem_re  out  1  data read strobe (LOAD)
- mem_we  out  1  data write strobe (STORE)
- dmem_addr  out  OPR_W  data address (= latched operand)
- dmem_ack  in  1  data access complete
- alu_op  out  3  ALU operation select
- reg_we  out  1  register-file write enable, one-cycle pulse
- pc  out  PC_W  current program counter
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- IDLE/HALT: on start, pc<=0, go FETCH. start ignored in all other states.
- FETCH: imem_req=1, held until imem_ack. On ack cycle: ir<=imem_rdata, go DECODE.
- DECODE: one cycle, no outputs. Opcode routing:
  - 0000 NOP, and any undefined opcode: pc<=pc+1, go FETCH.
  - 0001 ADD (alu_op 001), 0010 SUB (alu_op 010): go EXECUTE.
  - 0101 LOAD, 0110 STORE: go MEM.
  - 0111 JMP: pc<=operand, go FETCH.
  - 1111 HALT: go HALT; pc not advanced.
- EXECUTE: alu_op driven, reg_we=1 for exactly this cycle; pc<=pc+1; go FETCH.
- MEM: dmem_addr=operand. LOAD asserts dmem_re, STORE asserts mem_we; held until dmem_ack. On ack: LOAD goes WRITEBACK; STORE does pc<=pc+1 and goes FETCH.
- WRITEBACK: reg_we=1 for one cycle, pc<=pc+1, go FETCH.
- alu_op is 000 outside EXECUTE. reg_we, mem_we and dmem_re are never high together.
- pc arithmetic is modulo 2^PC_W: pc 4'hF + 1 wraps to 0. No overflow flag.

## Timing
- Reset (async assert, sync release): state=IDLE, pc=0, ir=0, every output 0. Assertion mid-handshake abandons it immediately; ack arriving after reset is ignored.
- Minimum latencies with zero-wait ack: NOP/JMP 2 cycles; ADD/SUB/STORE 3 cycles; LOAD 4 cycles (FETCH-DECODE-MEM-WRITEBACK).
- Each wait cycle without ack adds one cycle; request/strobe and address stay stable throughout.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- start coinciding with the HALT decode cycle is ignored; a new start is required.
- All outputs are registered or decoded from state/ir only, with no combinational path from ack to strobe.

## Structure
- Shared package proc_pkg: opcode constants (NOP, ADD, SUB, LOAD, STORE, JMP, HALT), ALU op codes (001 add, 010 sub), state enum.
- One sub-module: seq_pc, the PC register with clear/increment/load controls and modulo wrap.
- FSM and strobe decode stay in instr_sequencer.

## Test plan
- Reset then start; program ADD 3, SUB 1, HALT with zero-wait acks -> reg_we pulses at cycles 3 and 6 with alu_op 001 then 010, halted=1, pc=2.
- LOAD 9 with dmem_ack delayed 2 cycles -> dmem_re high 3 cycles, dmem_addr=9, then reg_we pulse one cycle later, pc increments by 1.
- STORE 4 -> mem_we high until dmem_ack, reg_we never asserted, dmem_addr=4.
- NOP at pc=F -> pc wraps to 0. JMP 5 -> next imem_addr=5.
- rst_n low during MEM of STORE -> mem_we drops immediately, state IDLE, pc=0; a later dmem_ack has no effect.
- Undefined opcode 1010 -> treated as NOP. start pulsed while busy -> ignored, pc unchanged.
